// File: rtl/dma_write_streamer.sv
// DMA write-back stage: buffers result beats, issues one write request, streams beats.
// Optional DMA_WR_CHECKSUM_EN appends an XOR checksum beat.
module dma_write_streamer #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          buf_we,
  input  logic [AW-1:0] buf_waddr,
  input  logic [63:0]   buf_wdata,
  input  logic          start,
  input  logic [31:0]   base_index,
  input  logic [31:0]   length,
  output logic          busy,
  output logic          done,
  output logic          len_err,
  input  logic          dma_write_ctrl_ready,
  output logic          dma_write_ctrl_valid,
  output logic [31:0]   dma_write_ctrl_data_index,
  output logic [31:0]   dma_write_ctrl_data_length,
  output logic [2:0]    dma_write_ctrl_data_size,
  output logic [5:0]    dma_write_ctrl_data_user,
  input  logic          dma_write_chnl_ready,
  output logic          dma_write_chnl_valid,
  output logic [63:0]   dma_write_chnl_data
);

  typedef enum logic [1:0] {IDLE, REQ, STREAM, DONE} state_t;

  localparam logic [AW:0]   DEPTH_N = DEPTH[AW:0];
  localparam logic [31:0]   DEPTH_W = DEPTH;
  localparam logic [AW:0]   ONE     = 1;
  localparam logic [AW-1:0] ADDR0   = '0;

  state_t       state_q, state_d;
  logic [63:0]  mem [DEPTH];
  logic [AW:0]  n_q, n_d;
  logic [AW:0]  ptr_q, ptr_d;
  logic [AW:0]  ptr_nxt, n_sel;
  logic         too_long, last;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         cv_q, cv_d;
  logic [31:0]  idx_q, idx_d;
  logic [31:0]  len_q, len_d;
  logic [2:0]   size_q, size_d;
  logic [5:0]   user_q, user_d;
  logic         chv_q, chv_d;
  logic [63:0]  data_q, data_d;
`ifdef DMA_WR_CHECKSUM_EN
  logic [63:0]  csum_q, csum_d;
  logic         tail_q, tail_d;
`endif

  // Buffer is frozen outside IDLE so in-flight beats stay coherent.
  always_ff @(posedge clk) begin
    if (buf_we && state_q == IDLE)
      mem[buf_waddr] <= buf_wdata;
  end

  always_comb begin
    too_long = length > DEPTH_W;
    n_sel    = too_long ? DEPTH_N : length[AW:0];
    ptr_nxt  = ptr_q + ONE;
    last     = ptr_nxt == n_q;
    state_d  = state_q;
    n_d      = n_q;
    ptr_d    = ptr_q;
    done_d   = 1'b0;
    err_d    = err_q;
    cv_d     = cv_q;
    idx_d    = idx_q;
    len_d    = len_q;
    size_d   = size_q;
    user_d   = user_q;
    chv_d    = chv_q;
    data_d   = data_q;
`ifdef DMA_WR_CHECKSUM_EN
    csum_d   = csum_q;
    tail_d   = tail_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d   = n_sel;
          err_d = too_long;
          ptr_d = '0;
`ifdef DMA_WR_CHECKSUM_EN
          csum_d = '0;
          tail_d = 1'b0;
`endif
          if (n_sel == '0) begin
            state_d = DONE;
          end else begin
            idx_d = base_index;
`ifdef DMA_WR_CHECKSUM_EN
            len_d = 32'(n_sel) + 32'd1;
`else
            len_d = 32'(n_sel);
`endif
            size_d  = 3'b011;
            user_d  = '0;
            cv_d    = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dma_write_ctrl_ready) begin
          cv_d    = 1'b0;
          chv_d   = 1'b1;
          data_d  = mem[ADDR0];
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (dma_write_chnl_ready) begin
`ifdef DMA_WR_CHECKSUM_EN
          if (tail_q) begin
            chv_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            csum_d = csum_q ^ data_q;
            if (last) begin
              data_d = csum_q ^ data_q;
              tail_d = 1'b1;
            end else begin
              ptr_d  = ptr_nxt;
              data_d = mem[ptr_nxt[AW-1:0]];
            end
          end
`else
          if (last) begin
            chv_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            ptr_d  = ptr_nxt;
            data_d = mem[ptr_nxt[AW-1:0]];
          end
`endif
        end
      end
      DONE: begin
        // Zero-length path enters here without a pulse; emit it now.
        done_d = !done_q;
        if (done_q)
          state_d = IDLE;
      end
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cv_q    <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      user_q  <= '0;
      chv_q   <= 1'b0;
      data_q  <= '0;
`ifdef DMA_WR_CHECKSUM_EN
      csum_q  <= '0;
      tail_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cv_q    <= cv_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      size_q  <= size_d;
      user_q  <= user_d;
      chv_q   <= chv_d;
      data_q  <= data_d;
`ifdef DMA_WR_CHECKSUM_EN
      csum_q  <= csum_d;
      tail_q  <= tail_d;
`endif
    end
  end

  assign busy                       = busy_q;
  assign done                       = done_q;
  assign len_err                    = err_q;
  assign dma_write_ctrl_valid       = cv_q;
  assign dma_write_ctrl_data_index  = idx_q;
  assign dma_write_ctrl_data_length = len_q;
  assign dma_write_ctrl_data_size   = size_q;
  assign dma_write_ctrl_data_user   = user_q;
  assign dma_write_chnl_valid       = chv_q;
  assign dma_write_chnl_data        = data_q;

endmodule

// File: doc/dma_write_streamer.md
# dma_write_streamer

Downstream write-back stage of the accelerator datapath. It holds the compute core's result beats in a local buffer, issues one ESP DMA write-control request, and streams the beats over the DMA write channel under valid/ready flow control. It signals completion with a one-cycle pulse that the top-level FSM uses to raise `acc_done`.

## Interface

Parameters:
- `DEPTH`, default 16: result buffer depth in 64-bit beats; power of two, ≥2.
- `AW`, default `$clog2(DEPTH)`: buffer address width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `buf_we` in 1: buffer write strobe from the compute core; honoured only in IDLE.
- `buf_waddr` in AW: buffer write address.
- `buf_wdata` in 64: buffer write data.
- `start` in 1: one-cycle pulse that launches a write-back; honoured only in IDLE.
- `base_index` in 32: DMA write offset in beats; sampled on `start`.
- `length` in 32: number of result beats; sampled on `start`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `len_err` out 1: sticky flag, set when `length > DEPTH`; cleared by the next accepted `start`.
- `dma_write_ctrl_ready` in 1 / `dma_write_ctrl_valid` out 1: write-request handshake.
- `dma_write_ctrl_data_index` out 32, `dma_write_ctrl_data_length` out 32, `dma_write_ctrl_data_size` out 3, `dma_write_ctrl_data_user` out 6: request fields.
- `dma_write_chnl_ready` in 1 / `dma_write_chnl_valid` out 1 / `dma_write_chnl_data` out 64: beat stream.

## Operation

- States: IDLE, REQ, STREAM, DONE.
- IDLE:
  - `buf_we` writes `buf_wdata` to `buf[buf_waddr]`.
  - On `start`: latch `N = min(length, DEPTH)`, set `len_err = (length > DEPTH)`, clear the beat pointer.
  - If N = 0, go to DONE. No DMA request is issued.
  - Otherwise load the ctrl fields (index = `base_index`, length = N, size = 3'b011, user = 0), assert `dma_write_ctrl_valid`, and go to REQ.
- REQ:
  - Hold valid and all fields stable until `dma_write_ctrl_ready`.
  - On handshake: drop ctrl valid, register `buf[0]` onto chnl data, assert `dma_write_chnl_valid`, and go to STREAM.
- STREAM:
  - On each chnl handshake, increment the pointer p and register `buf[p+1]` in the same cycle.
  - While ready is low, valid and data hold stable.
  - When beat N−1 is accepted, drop chnl valid and go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- Ignored inputs:
  - `start` while busy.
  - `buf_we` while busy. The buffer is frozen during a transfer.
- Pointer is AW+1 bits wide. No wrap-around occurs because N ≤ DEPTH.

## Timing

- All outputs are registered.
- Reset values:
  - `busy`, `done`, `len_err`, both valids = 0.
  - All ctrl fields = 0.
  - chnl data = 0.
  - Buffer contents are not reset.
- Reset mid-operation: immediate return to IDLE with the reset values above. No further beats are issued.
- Latency, ready always high and `start` at cycle 0:
  - ctrl valid at cycle 1, accepted at cycle 1.
  - Beats at cycles 2..N+1.
  - `done` at cycle N+2.
- N = 0: `done` at cycle 2.
- Throughput: one beat per cycle while ready is held high.
- `start` and `buf_we` in the same IDLE cycle: the write completes, but beat data is sampled from the buffer only at the REQ→STREAM transition or later. A write to address 0 in the `start` cycle is therefore included in the transfer.

## Configuration

- Macro `DMA_WR_CHECKSUM_EN`.
- Defined:
  - Request length = N+1.
  - After beat N−1 is accepted, one extra beat carries the XOR of all N data beats, with the same hold-on-not-ready rule.
  - `done` follows acceptance of the checksum beat, at cycle N+3 with ready always high.
  - N = 0 still issues no request.
- Undefined: exactly N beats, and no XOR logic is present.

## Test plan

- **Basic:** load `buf[i] = 64'h1000+i` for i = 0..15, start with `base_index` = 8 and `length` = 16, ready held high.
  - Ctrl fields are 8 / 16 / 3'b011 / 0.
  - Beats 0x1000..0x100F arrive in order, one per cycle.
  - `done` pulses at cycle 18. `len_err` = 0.
- **Backpressure:** `length` = 4 with chnl ready toggling every cycle, and ctrl ready delayed 5 cycles.
  - ctrl valid holds for 5 cycles.
  - Each beat is held stable until accepted.
  - Exactly 4 handshakes, then `done`.
- **Boundaries:**
  - `length` = 0: no ctrl valid, `done` at cycle 2.
  - `length` = 20: request length 16, 16 beats, `len_err` = 1; the next `start` with `length` = 2 clears it.
- **Ignored inputs during transfer:** pulse `start` and `buf_we` (`buf[0]` = 0xDEAD) in mid-STREAM.
  - No second request is issued.
  - A following transfer still reads the old `buf[0]`.
- **Reset:** assert `rst_n` low after beat 3 of 16.
  - All outputs return to 0 asynchronously.
  - After release, a new `start` completes normally.
- **`DMA_WR_CHECKSUM_EN`:** beats 1, 2, 4, 8 produce request length 5, a final beat of 0xF, and `done` at cycle 7.
